// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU constants for the fetch slice.
//   CPU_ADDR_W   - default instruction word-address width
//   CPU_DATA_W   - default instruction width
//   CPU_START_PC - default PC loaded on reset
//   out_src_e    - source selected for the fetch output register each cycle
package fetch_unit_pkg;

    localparam int unsigned CPU_ADDR_W   = 8;
    localparam int unsigned CPU_DATA_W   = 32;
    localparam int unsigned CPU_START_PC = 0;

    typedef enum logic [1:0] {
        SRC_HOLD = 2'd0,  // output stalled, keep contents
        SRC_SKID = 2'd1,  // drain the skid entry
        SRC_RESP = 2'd2,  // take the RAM response directly
        SRC_NONE = 2'd3   // nothing to load, go invalid
    } out_src_e;

endpackage

// File: rtl/fetch_unit_skid_stage.sv
// skid_stage: valid/ready output register backed by a one-entry skid buffer.
// Absorbs the one response that is already in flight from the RAM when the
// consumer stalls, so nothing is dropped or duplicated.
//   clk, rst      - clock, asynchronous active-high reset
//   i_flush       - synchronous flush: invalidates output and skid
//   i_in_valid    - a RAM response is present this cycle
//   i_in_instr    - response data
//   i_in_pc       - word address of the response
//   i_out_ready   - consumer accepts the current output
//   o_out_valid   - output holds a valid instruction
//   o_out_instr   - output instruction
//   o_out_pc      - output word address
//   o_skid_valid  - skid buffer occupied (used by the issue logic)
module skid_stage
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_instr,
    input  logic [ADDR_W-1:0] i_in_pc,
    input  logic              i_out_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0] o_out_pc,
    output logic              o_skid_valid
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [ADDR_W-1:0] r_out_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0] r_skid_pc;

    logic              w_load;
    logic              w_capture;
    out_src_e          w_src;

    always_comb begin
        w_load = !r_out_valid || i_out_ready;
        w_src  = SRC_HOLD;
        if (w_load) begin
            if (r_skid_valid)
                w_src = SRC_SKID;
            else if (i_in_valid)
                w_src = SRC_RESP;
            else
                w_src = SRC_NONE;
        end
        // Capture a response either because the output is stalled, or
        // because the skid is draining this cycle (pass-through refill).
        w_capture = i_in_valid && (!w_load || r_skid_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            case (w_src)
                SRC_SKID: begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= r_skid_instr;
                    r_out_pc    <= r_skid_pc;
                end
                SRC_RESP: begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= i_in_instr;
                    r_out_pc    <= i_in_pc;
                end
                SRC_NONE: r_out_valid <= 1'b0;
                default:  ;
            endcase

            if (w_capture) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= i_in_instr;
                r_skid_pc    <= i_in_pc;
            end else if (w_src == SRC_SKID) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_instr  = r_out_instr;
    assign o_out_pc     = r_out_pc;
    assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Issues sequential word addresses to the read port of the instruction RAM
// (1-cycle registered read), and hands instructions plus their PCs to decode
// over valid/ready. A branch redirect from execute flushes everything in
// flight and restarts fetch at the target.
//   clk, rst   - clock, asynchronous active-high reset
//   imem_addr  - RAM read address (current pc, combinational)
//   imem_data  - RAM read data, valid the cycle after the address
//   br_valid   - redirect request
//   br_target  - redirect word address
//   out_valid  - out_instr/out_pc valid
//   out_instr  - instruction to decode
//   out_pc     - word address of out_instr
//   out_ready  - decode accepts the current output
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W   = CPU_ADDR_W,
    parameter int unsigned DATA_W   = CPU_DATA_W,
    parameter int unsigned START_PC = CPU_START_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_pc;

    logic              w_issue;
    logic              w_skid_valid;
    logic              w_out_valid;

    // Stop issuing once the skid is occupied, or when the response now
    // returning will itself have to go to the skid: that bounds the
    // fetched-but-unaccepted instructions to output + skid.
    always_comb begin
        w_issue = !br_valid && !w_skid_valid
                  && !(r_req_valid && w_out_valid && !out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= ADDR_W'(START_PC);
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
        end else if (br_valid) begin
            r_pc        <= br_target;
            r_req_valid <= 1'b0;
        end else if (w_issue) begin
            r_pc        <= r_pc + ADDR_W'(1);
            r_req_valid <= 1'b1;
            r_req_pc    <= r_pc;
        end else begin
            r_req_valid <= 1'b0;
        end
    end

    assign imem_addr = r_pc;

    skid_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid_stage (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (br_valid),
        .i_in_valid   (r_req_valid),
        .i_in_instr   (imem_data),
        .i_in_pc      (r_req_pc),
        .i_out_ready  (out_ready),
        .o_out_valid  (w_out_valid),
        .o_out_instr  (out_instr),
        .o_out_pc     (out_pc),
        .o_skid_valid (w_skid_valid)
    );

    assign out_valid = w_out_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit.
// Reference model: the program-order stream of accepted PCs (next expected
// PC, restarted at each redirect/reset), the RAM contents as a formula, the
// hold-while-stalled rule and the bound on unaccepted fetched instructions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic        br_valid = 1'b0;
    logic [7:0]  br_target = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0]  exp_pc = '0;
    bit          stall_prev = 1'b0;
    logic [7:0]  hold_pc = '0;
    logic [31:0] hold_instr = '0;
    int unsigned n_acc = 0;
    logic [7:0]  acc_q[$];

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .START_PC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .br_valid  (br_valid),
        .br_target (br_target),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // RAM port B model: registered read, contents A000_0000 + address.
    always @(posedge clk) imem_data <= 32'hA000_0000 + {24'h0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input bit rdy, input bit br, input logic [7:0] tgt);
        logic [7:0] occ;
        out_ready = rdy;
        br_valid  = br;
        br_target = tgt;
        if (stall_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", 32'(out_pc), 32'(hold_pc));
            chk("hold_instr", out_instr, hold_instr);
        end
        occ = imem_addr - exp_pc;
        chk("occupancy", 32'(occ <= 8'd2), 32'd1);
        if (out_valid && rdy) begin
            chk("xfer_pc", 32'(out_pc), 32'(exp_pc));
            chk("xfer_instr", out_instr, 32'hA000_0000 + 32'(exp_pc));
            acc_q.push_back(out_pc);
            exp_pc = exp_pc + 8'd1;
            n_acc++;
        end
        if (br) exp_pc = tgt;
        stall_prev = out_valid && !rdy && !br;
        hold_pc    = out_pc;
        hold_instr = out_instr;
        @(negedge clk);
    endtask

    initial begin
        int unsigned k;
        int unsigned acc0;
        logic [7:0]  a;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        // First fetch latency and unstalled throughput
        rst = 1'b0;
        cyc(1, 0, 8'h00);
        chk("lat_v1", 32'(out_valid), 32'd0);
        cyc(1, 0, 8'h00);
        chk("lat_v2", 32'(out_valid), 32'd1);
        chk("lat_pc0", 32'(out_pc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00);
            chk("thru_valid", 32'(out_valid), 32'd1);
        end
        chk("thru_pc3", 32'(out_pc), 32'd3);

        // Stall with out_pc=3: address freezes, output held
        a = imem_addr;
        chk("stall_addr", 32'(a), 32'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 8'h00);
            chk("stall_frozen", 32'(imem_addr), 32'(a));
        end
        k = 0;
        while (n_acc < 7 && k < 12) begin
            cyc(1, 0, 8'h00);
            k++;
        end
        chk("release_acc", 32'(n_acc >= 7), 32'd1);

        // Redirect while stalled on out_pc=7 with skid full
        k = 0;
        while (!(out_valid && out_pc == 8'd7) && k < 12) begin
            cyc(1, 0, 8'h00);
            k++;
        end
        chk("reach_pc7", 32'(out_valid && out_pc == 8'd7), 32'd1);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 1, 8'h40);
        chk("br_v1", 32'(out_valid), 32'd0);
        chk("br_addr", 32'(imem_addr), 32'h40);
        cyc(1, 0, 8'h00);
        chk("br_v2", 32'(out_valid), 32'd0);
        cyc(1, 0, 8'h00);
        chk("br_v3", 32'(out_valid), 32'd1);
        chk("br_pc", 32'(out_pc), 32'h40);
        repeat (4) cyc(1, 0, 8'h00);

        // Wrap-around from 0xFE
        cyc(1, 1, 8'hFE);
        acc0 = n_acc;
        k = 0;
        while (n_acc < acc0 + 4 && k < 12) begin
            cyc(1, 0, 8'h00);
            k++;
        end
        chk("wrap_count", 32'(n_acc - acc0), 32'd4);
        if (acc_q.size() >= 4) begin
            chk("wrap_0", 32'(acc_q[acc_q.size()-4]), 32'hFE);
            chk("wrap_1", 32'(acc_q[acc_q.size()-3]), 32'hFF);
            chk("wrap_2", 32'(acc_q[acc_q.size()-2]), 32'h00);
            chk("wrap_3", 32'(acc_q[acc_q.size()-1]), 32'h01);
        end

        // Toggling ready
        for (int i = 0; i < 20; i++) cyc((i % 2) == 0, 0, 8'h00);

        // Random ready/redirect traffic
        acc0 = n_acc;
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                8'($urandom_range(0, 255)));
        chk("rand_progress", 32'((n_acc - acc0) >= 40), 32'd1);

        // Asynchronous reset mid-stall
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", 32'(out_pc), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        exp_pc     = 8'd0;
        stall_prev = 1'b0;
        cyc(1, 0, 8'h00);
        chk("rs_v1", 32'(out_valid), 32'd0);
        cyc(1, 0, 8'h00);
        chk("rs_v2", 32'(out_valid), 32'd1);
        chk("rs_pc", 32'(out_pc), 32'd0);
        repeat (6) cyc(1, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
